// File: rtl/rib_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rib_apb_pkg
// Description : Shared types and constants for the bus-to-APB3 bridge.
//               Holds the bridge state encoding, the read data returned on
//               a timed-out read, and the {psel,penable} phase encodings
//               used by the bridge's protocol assertions.
// Revision    : 1.0 - initial release
// ============================================================================
package rib_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Read data substituted when a peripheral never raises pready.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // APB phase encodings, expressed as {psel, penable}.
    localparam logic [1:0] APB_IDLE   = 2'b00;
    localparam logic [1:0] APB_SETUP  = 2'b10;
    localparam logic [1:0] APB_ACCESS = 2'b11;

endpackage : rib_apb_pkg
`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : apb_timeout_cnt
// Description : Wait-state counter for the APB ACCESS phase. Counts cycles
//               in which the peripheral holds pready low and flags the last
//               permitted wait cycle so the bridge can abort the transfer.
// Ports       : clk     - system clock
//               rst     - asynchronous active-high reset
//               clr     - synchronous clear (has priority over en)
//               en      - count enable
//               expired - high while count == TIMEOUT-1
// Revision    : 1.0 - initial release
// ============================================================================
module apb_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned      CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // The abort fires at TIMEOUT-1 and clears the count, so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign expired = (r_cnt == c_LAST);

endmodule : apb_timeout_cnt
`default_nettype wire

// File: rtl/rib_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : rib_apb_bridge
// Description : Converts one system-bus slave-port access into one APB3
//               transfer. Stalls the bus through hold_o until the transfer
//               completes, then reports completion with a one-cycle ack_o
//               (err_o flags pslverr or a pready timeout).
// Ports       : clk, rst            - clock, async active-high reset
//               req_i/addr_i/data_i/we_i - bus access request side
//               data_o/ack_o/err_o  - bus completion side
//               hold_o              - stall request to the arbiter
//               psel_o/penable_o/pwrite_o/paddr_o/pwdata_o - APB master out
//               prdata_i/pready_i/pslverr_i                - APB master in
// Revision    : 1.0 - initial release
// ============================================================================
module rib_apb_bridge
    import rib_apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              we_i,
    output logic [DATA_W-1:0] data_o,
    output logic              ack_o,
    output logic              err_o,
    output logic              hold_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);

    state_t            r_state;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ack;
    logic              r_err;

    logic              w_in_access;
    logic              w_cnt_clr;
    logic              w_cnt_en;
    logic              w_expired;

    // Counter runs only across wait states; any exit from ACCESS clears it.
    assign w_in_access = (r_state == ACCESS);
    assign w_cnt_en    = w_in_access & ~pready_i;
    assign w_cnt_clr   = ~w_in_access | pready_i | w_expired;

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_cnt_clr),
        .en      (w_cnt_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_rdata   <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // ack/err are single-cycle pulses asserted only in DONE.
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_i) begin
                        r_paddr  <= addr_i;
                        r_pwdata <= data_i;
                        r_pwrite <= we_i;
                        r_psel   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    // pready wins over the timeout on the last permitted cycle.
                    if (pready_i) begin
                        r_err <= pslverr_i;
                        if (!r_pwrite) begin
                            r_rdata <= prdata_i;
                        end
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_ack     <= 1'b1;
                        r_state   <= DONE;
                    end else if (w_expired) begin
                        r_err <= 1'b1;
                        if (!r_pwrite) begin
                            r_rdata <= DATA_W'(TIMEOUT_RDATA);
                        end
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_ack     <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Combinational in IDLE so the requesting master stalls in the same cycle.
    assign hold_o = ((r_state == IDLE) & req_i) |
                    (r_state == SETUP) |
                    (r_state == ACCESS);

    assign psel_o    = r_psel;
    assign penable_o = r_penable;
    assign pwrite_o  = r_pwrite;
    assign paddr_o   = r_paddr;
    assign pwdata_o  = r_pwdata;
    assign data_o    = r_rdata;
    assign ack_o     = r_ack;
    assign err_o     = r_err;

    a_apb_phase : assert property (@(posedge clk) disable iff (rst)
        (({r_psel, r_penable} == APB_IDLE) ||
         ({r_psel, r_penable} == APB_SETUP) ||
         ({r_psel, r_penable} == APB_ACCESS)));

    a_ack_drops_psel : assert property (@(posedge clk) disable iff (rst)
        (r_ack |-> !r_psel));

endmodule : rib_apb_bridge
`default_nettype wire

// File: doc/rib_apb_bridge.md
Name: rib_apb_bridge

Overview:
- Downstream stage of the 4-master/6-slave system bus. Attaches to one bus slave port (sN_addr_o/sN_data_o/sN_we_o/sN_data_i) and converts each bus access into one APB3 transfer to a low-speed peripheral cluster.
- Stalls the bus via hold_o, which is ORed into the arbiter's hold_flag_o, until the APB transfer completes.
- Adds a bounded-wait timeout so a dead peripheral cannot hang the pipeline.

Parameters:
- ADDR_W, 32, bus/APB address width.
- DATA_W, 32, bus/APB data width.
- TIMEOUT, 255, max ACCESS cycles waiting for pready before abort. Range 1..65535.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_i  in  1  bus access request from slave port select
- addr_i  in  ADDR_W  bus address (sN_addr_o)
- data_i  in  DATA_W  bus write data (sN_data_o)
- we_i  in  1  1=write, 0=read (sN_we_o)
- data_o  out  DATA_W  read data to bus (sN_data_i)
- ack_o  out  1  one-cycle completion pulse
- err_o  out  1  completion had pslverr or timeout; valid with ack_o
- hold_o  out  1  stall request to arbiter
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB direction
- paddr_o  out  ADDR_W  APB address
- pwdata_o  out  DATA_W  APB write data
- prdata_i  in  DATA_W  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error

Behaviour:
- Reset (async, any state):
  - State goes to IDLE. psel_o, penable_o, pwrite_o, ack_o, err_o, hold_o are 0. paddr_o, pwdata_o, data_o are 0. Timeout counter is 0.
  - Reset mid-transfer drops psel/penable immediately. No completion is reported.
- FSM states are IDLE, SETUP, ACCESS, DONE.
  - IDLE: if req_i=1, latch addr_i, data_i, we_i into paddr/pwdata/pwrite registers, then go to SETUP. Otherwise stay.
  - SETUP: psel_o=1, penable_o=0. Exactly one cycle, then ACCESS.
  - ACCESS: psel_o=1, penable_o=1.
    - If pready_i=1: sample pslverr_i into err. If read, capture prdata_i into data_o. Go to DONE. Counter clears.
    - Else if counter==TIMEOUT-1: abort. err=1, data_o=TIMEOUT_RDATA (0xDEAD_BEEF) for reads. Go to DONE.
    - Else: counter increments and FSM stays in ACCESS.
  - DONE: psel_o=0, penable_o=0, ack_o=1, err_o=err. Go to IDLE. req_i is ignored in DONE.
- hold_o = (IDLE & req_i) | SETUP | ACCESS. It is combinational in IDLE so the requesting master stalls in the same cycle. It is 0 in DONE.
- pslverr_i and prdata_i are ignored unless ACCESS & pready_i.
- paddr/pwdata/pwrite stay stable from SETUP through the last ACCESS cycle. Changes on addr_i/data_i/we_i during a transfer have no effect.
- data_o holds the last read value. Writes do not change it. err_o is 0 outside DONE.
- Latency with a zero-wait slave:
  - req seen in cycle 0 (IDLE), SETUP in cycle 1, ACCESS in cycle 2, DONE/ack in cycle 3.
  - Each pready wait state adds one cycle.
- Back-to-back requests: minimum spacing is 4 cycles. A new request is accepted in the IDLE cycle after DONE.
- Timeout counter is width clog2(TIMEOUT+1). It never wraps because the abort fires at TIMEOUT-1.

Decomposition:
- Package rib_apb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, DONE), 2 bits;
  - localparam TIMEOUT_RDATA = 32'hDEAD_BEEF;
  - APB_IDLE/SETUP/ACCESS phase encodings for assertions.
- Sub-module apb_timeout_cnt holds the counter. Ports: clk, rst, clr, en, expired. Parameter TIMEOUT.
- FSM and datapath registers stay in rib_apb_bridge.

Test Plan:
- Read, zero wait: req_i=1, we_i=0, addr_i=0x1000_0004, prdata_i=0x1234_5678, pready_i=1 in ACCESS.
  - psel_o=1 in cycle 1; penable_o=1 in cycle 2; ack_o=1, data_o=0x1234_5678, err_o=0 in cycle 3.
  - hold_o=1 in cycles 0–2 and 0 in cycle 3.
- Write, 3 wait states: we_i=1, addr_i=0x1000_0008, data_i=0xA5A5_0001. pready low for 3 ACCESS cycles.
  - pwrite_o=1, paddr_o/pwdata_o stable through all 4 ACCESS cycles.
  - ack_o in cycle 6; data_o unchanged.
- Slave error: read with pslverr_i=1 and pready_i=1 → ack_o=1, err_o=1, data_o=prdata_i.
- Timeout: TIMEOUT=4, pready_i tied 0 → ACCESS lasts 4 cycles, then ack_o=1, err_o=1, data_o=0xDEAD_BEEF, psel_o=0.
- Reset mid-ACCESS: assert rst asynchronously between clock edges → psel_o/penable_o/hold_o go to 0 before the next edge. No ack_o. A new request after release completes normally.
- Back-to-back: req_i held 1 for two reads with different addresses → second SETUP starts in cycle 5. Exactly two ack_o pulses, each with correct data.
